score_display: RTL and testbench

- Downstream consumer of the game top's four BCD score digits.
- Keeps a session high score, selects between live score and high score, blanks leading zeros, and time-multiplexes the value onto a 4-digit common-anode seven-segment display.
- Blinks the display while a newly set high score is shown on the game-over screen.
- Sits between the score counter/game FSM and the board's segment/anode pins.

---
 rtl/dinorun_pkg.sv | 19 +
 rtl/score_display_if.sv | 32 +++
 rtl/score_display_seg7_decode.sv | 18 +
 rtl/score_display.sv | 128 ++++++++++++
 tb/tb_score_display.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dinorun_pkg.sv
// Shared types and seven-segment encodings for the score path and display.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package dinorun_pkg;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [3:0] score_t;

    localparam logic [6:0] Seg7Blank = 7'h7F;
    localparam logic [6:0] Seg7Dash  = 7'h3F;
    localparam logic [6:0] Seg7Digits [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic is_dash(input bcd_t d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Score-in / segment-out bundle between the game logic and the display driver.
// No handshake: every input is a level or single-cycle pulse sampled each clock.
interface score_display_if;
    import dinorun_pkg::*;

    logic        frame_i;
    bcd_t        digit0_i;
    bcd_t        digit1_i;
    bcd_t        digit2_i;
    bcd_t        digit3_i;
    logic        game_over_i;
    logic        show_hi_i;
    logic        clear_hi_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        new_hi_o;
    logic [15:0] hi_o;

    modport master (
        output frame_i, digit0_i, digit1_i, digit2_i, digit3_i,
        output game_over_i, show_hi_i, clear_hi_i,
        input  seg_o, dp_o, an_o, new_hi_o, hi_o
    );

    modport slave (
        input  frame_i, digit0_i, digit1_i, digit2_i, digit3_i,
        input  game_over_i, show_hi_i, clear_hi_i,
        output seg_o, dp_o, an_o, new_hi_o, hi_o
    );

endinterface

// File: rtl/score_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; purely combinational.
// Values above 9 show a dash and ignore the blank flag.
module seg7_decode
    import dinorun_pkg::*;
(
    input  bcd_t       digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = Seg7Dash;
        if (!is_dash(digit_i)) begin
            seg_o = blank_i ? Seg7Blank : Seg7Digits[digit_i];
        end
    end

endmodule

// File: rtl/score_display.sv
// High-score tracking and 4-digit multiplexed seven-segment driver with blink.
// Outputs registered one cycle after the refresh counter; no backpressure.
module score_display
    import dinorun_pkg::*;
#(
    parameter int RefreshBits = 15,
    parameter int BlinkFrames = 30
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    score_display_if.slave bus
);

    localparam int SlotW  = RefreshBits - 2;
    localparam int BlinkW = (BlinkFrames > 1) ? $clog2(BlinkFrames) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BlinkFrames - 1);

    logic [RefreshBits-1:0] refresh_q, refresh_d;
    logic                   go_q, go_d;
    logic [15:0]            hi_q, hi_d;
    logic                   new_hi_q, new_hi_d;
    logic [BlinkW-1:0]      blink_cnt_q, blink_cnt_d;
    logic                   blink_ph_q, blink_ph_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [3:0]             an_q, an_d;

    score_t      score, disp;
    logic [15:0] score_v;
    logic [1:0]  sel;
    logic        guard;
    logic        go_rise;
    logic        blink_act;
    logic [3:0]  blank;
    logic [6:0]  cur_seg;

    assign score   = {bus.digit3_i, bus.digit2_i, bus.digit1_i, bus.digit0_i};
    assign score_v = score;
    assign disp    = bus.show_hi_i ? score_t'(hi_q) : score;
    assign sel     = refresh_q[RefreshBits-1 -: 2];
    // Anodes stay dark for the first 4 cycles of every slot to avoid ghosting.
    assign guard   = {{(32-SlotW){1'b0}}, refresh_q[SlotW-1:0]} < 32'd4;
    assign go_rise   = bus.game_over_i && !go_q;
    assign blink_act = new_hi_q && bus.game_over_i;

    always_comb begin
        blank    = 4'b0000;
        blank[3] = (disp[3] == 4'd0);
        blank[2] = blank[3] && (disp[2] == 4'd0);
        blank[1] = blank[2] && (disp[1] == 4'd0);
    end

    seg7_decode u_decode (
        .digit_i (disp[sel]),
        .blank_i (blank[sel]),
        .seg_o   (cur_seg)
    );

    always_comb begin
        refresh_d = refresh_q + RefreshBits'(1);
        go_d      = bus.game_over_i;

        hi_d     = hi_q;
        new_hi_d = new_hi_q;
        if (bus.clear_hi_i) begin
            hi_d     = '0;
            new_hi_d = 1'b0;
        end else if (go_rise && (score_v > hi_q)) begin
            hi_d     = score_v;
            new_hi_d = 1'b1;
        end else if (!bus.game_over_i) begin
            new_hi_d = 1'b0;
        end

        // Held at zero while idle so every blink sequence starts in the lit phase.
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (!blink_act) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (bus.frame_i) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_ph_d  = !blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end

        seg_d = cur_seg;
        dp_d  = !((sel == 2'd3) && bus.show_hi_i);
        an_d  = 4'hF;
        if (!guard && !blink_ph_q) begin
            an_d[sel] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            refresh_q   <= '0;
            go_q        <= 1'b0;
            hi_q        <= '0;
            new_hi_q    <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= Seg7Blank;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
        end else begin
            refresh_q   <= refresh_d;
            go_q        <= go_d;
            hi_q        <= hi_d;
            new_hi_q    <= new_hi_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign bus.seg_o    = seg_q;
    assign bus.dp_o     = dp_q;
    assign bus.an_o     = an_q;
    assign bus.new_hi_o = new_hi_q;
    assign bus.hi_o     = hi_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: stimulus queues expected values per cycle,
// a monitor compares them against the DUT just after each rising edge.
`timescale 1ns/1ps
module tb_score_display;

    localparam int RB    = 5;
    localparam int BF    = 2;
    localparam int K_SEG = 0;
    localparam int K_AN  = 1;
    localparam int K_DP  = 2;
    localparam int K_HI  = 3;
    localparam int K_NEW = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   c0    = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];

    score_display_if bus();

    score_display #(.RefreshBits(RB), .BlinkFrames(BF)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        logic [15:0] act;
        case (e.kind)
            K_SEG:   act = {9'd0, bus.seg_o};
            K_AN:    act = {12'd0, bus.an_o};
            K_DP:    act = {15'd0, bus.dp_o};
            K_HI:    act = bus.hi_o;
            default: act = {15'd0, bus.new_hi_o};
        endcase
        n_vec++;
        if (e.cyc != cyc || act !== e.val) begin
            n_bad++;
            $display("FAIL %s cyc %0d (due %0d): got %h want %h", e.name, cyc, e.cyc, act, e.val);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                check(q[i]);
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int c, input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_score(input logic [15:0] s);
        bus.digit3_i = s[15:12];
        bus.digit2_i = s[11:8];
        bus.digit1_i = s[7:4];
        bus.digit0_i = s[3:0];
    endtask

    // Cycle at which the registered outputs reflect refresh count p*32+s*8+off.
    function automatic int disp_cyc(input int p, input int s, input int off);
        return c0 + 1 + p * 32 + s * 8 + off;
    endfunction

    function automatic logic [3:0] lit_an(input int s);
        logic [3:0] a;
        a    = 4'hF;
        a[s] = 1'b0;
        return a;
    endfunction

    function automatic int next_lit(input int from);
        int c;
        c = from;
        while (((c - c0 - 1) & 7) < 4) c++;
        return c;
    endfunction

    function automatic int sel_of(input int c);
        return ((c - c0 - 1) >> 3) & 3;
    endfunction

    task automatic scan_period(input int p, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input logic dp3, input string nm);
        logic [6:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int s = 0; s < 4; s++) begin
            expect_at(disp_cyc(p, s, 0), K_AN, 16'h000F, {nm, "_guard0"});
            expect_at(disp_cyc(p, s, 3), K_AN, 16'h000F, {nm, "_guard3"});
            expect_at(disp_cyc(p, s, 4), K_AN, {12'd0, lit_an(s)}, {nm, "_an"});
            expect_at(disp_cyc(p, s, 5), K_SEG, {9'd0, e[s]}, {nm, "_seg"});
            expect_at(disp_cyc(p, s, 6), K_DP, (s == 3) ? {15'd0, dp3} : 16'd1, {nm, "_dp"});
        end
    endtask

    task automatic hi_event(input logic [15:0] s, input logic clr,
                            input logic [15:0] hi_exp, input logic new_exp, input string nm);
        set_score(s);
        bus.game_over_i = 1'b1;
        bus.clear_hi_i  = clr;
        expect_at(cyc + 1, K_HI, hi_exp, {nm, "_hi"});
        expect_at(cyc + 1, K_NEW, {15'd0, new_exp}, {nm, "_new"});
        step(1);
        bus.clear_hi_i = 1'b0;
    endtask

    initial begin
        int x;
        int c;
        exp_t e;
        bus.frame_i     = 1'b0;
        bus.game_over_i = 1'b0;
        bus.show_hi_i   = 1'b0;
        bus.clear_hi_i  = 1'b0;
        set_score(16'h0000);

        step(2);
        expect_at(cyc + 1, K_SEG, 16'h007F, "rst_seg");
        expect_at(cyc + 1, K_AN,  16'h000F, "rst_an");
        expect_at(cyc + 1, K_DP,  16'h0001, "rst_dp");
        expect_at(cyc + 1, K_HI,  16'h0000, "rst_hi");
        expect_at(cyc + 1, K_NEW, 16'h0000, "rst_new");
        step(3);

        set_score(16'h0012);
        rst_n = 1'b1;
        c0    = cyc;
        scan_period(0, 7'h24, 7'h79, 7'h7F, 7'h7F, 1'b1, "p0_0012");

        to_cyc(c0 + 32);
        set_score(16'h0000);
        scan_period(1, 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b1, "p1_0000");

        to_cyc(c0 + 64);
        set_score(16'h0C00);
        scan_period(2, 7'h40, 7'h40, 7'h3F, 7'h7F, 1'b1, "p2_dash");

        to_cyc(c0 + 96);
        set_score(16'h0012);
        bus.show_hi_i = 1'b1;
        scan_period(3, 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b0, "p3_showhi");

        to_cyc(c0 + 128);
        bus.show_hi_i = 1'b0;
        step(2);

        hi_event(16'h0150, 1'b0, 16'h0150, 1'b1, "hi150");
        step(1);
        bus.game_over_i = 1'b0;
        expect_at(cyc + 1, K_NEW, 16'h0000, "hi150_drop_new");
        step(3);

        hi_event(16'h0230, 1'b0, 16'h0230, 1'b1, "hi230");
        expect_at(cyc + 2, K_NEW, 16'h0001, "hi230_hold_new");
        step(1);

        // Align so the two cycles after the first pulse land in the lit half of a slot.
        while (((cyc + 2 - c0 - 1) & 7) != 4) step(1);
        x = cyc;
        bus.frame_i = 1'b1;
        expect_at(x + 2, K_AN, {12'd0, lit_an(sel_of(x + 2))}, "blink_pulse1_lit");
        expect_at(x + 3, K_AN, {12'd0, lit_an(sel_of(x + 3))}, "blink_pulse1_lit2");
        step(1);
        bus.frame_i = 1'b0;
        step(1);
        bus.frame_i = 1'b1;
        step(1);
        bus.frame_i = 1'b0;
        c = next_lit(x + 4);
        expect_at(c, K_AN, 16'h000F, "blink_off");
        expect_at(c + 1, K_AN, 16'h000F, "blink_off2");
        to_cyc(c + 1);
        bus.frame_i = 1'b1;
        step(1);
        bus.frame_i = 1'b0;
        step(1);
        bus.frame_i = 1'b1;
        x = cyc;
        step(1);
        bus.frame_i = 1'b0;
        c = next_lit(x + 2);
        expect_at(c, K_AN, {12'd0, lit_an(sel_of(c))}, "blink_restored");
        expect_at(c, K_NEW, 16'h0001, "blink_new_hold");
        to_cyc(c + 1);
        bus.game_over_i = 1'b0;
        expect_at(cyc + 1, K_NEW, 16'h0000, "hi230_drop_new");
        step(3);

        hi_event(16'h0100, 1'b0, 16'h0230, 1'b0, "lower");
        step(1);
        bus.game_over_i = 1'b0;
        step(3);

        hi_event(16'h0230, 1'b0, 16'h0230, 1'b0, "equal");
        step(1);
        bus.game_over_i = 1'b0;
        step(3);

        hi_event(16'h0999, 1'b1, 16'h0000, 1'b0, "clear_vs_rise");
        expect_at(cyc + 2, K_HI, 16'h0000, "clear_hold_hi");
        step(3);
        bus.game_over_i = 1'b0;
        step(3);

        hi_event(16'h0001, 1'b0, 16'h0001, 1'b1, "after_clear");
        step(3);

        #2;
        rst_n = 1'b0;
        #1;
        e.cyc = cyc; e.kind = K_HI; e.val = 16'h0000; e.name = "async_rst_hi";
        check(e);
        e.kind = K_NEW; e.name = "async_rst_new";
        check(e);
        step(1);
        expect_at(cyc + 1, K_AN,  16'h000F, "midrst_an");
        expect_at(cyc + 1, K_SEG, 16'h007F, "midrst_seg");
        expect_at(cyc + 1, K_HI,  16'h0000, "midrst_hi");

        for (int t = 0; t < 200 && q.size() > 0; t++) step(1);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s never checked (due %0d)", e.name, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
